ehl_shift_buffer: RTL and testbench

EHL_SHIFT_BUFFER -- requirements
Module: ehl_shift_buffer

---
 rtl/ehl_buffer_pkg.sv | 15 +
 rtl/ehl_buffer_level_ctrl.sv | 64 ++++++
 rtl/ehl_shift_buffer.sv | 134 +++++++++++++
 tb/tb_ehl_shift_buffer.sv | 100 ++++++++++
 4 files changed

// File: rtl/ehl_buffer_pkg.sv
// Shared definitions for the ehl buffer family.
//   ehl_buf_mode_e : storage organisation selected by the MODE parameter
//   level_width()  : bit width of an entry counter able to hold 0..depth
package ehl_buffer_pkg;

  typedef enum logic {
    EHL_BUF_WR_PTR = 1'b0,  // write by pointer, read by shift
    EHL_BUF_RD_PTR = 1'b1   // write by shift, read by pointer
  } ehl_buf_mode_e;

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ehl_buffer_level_ctrl.sv
// Entry counter and registered status flags for the ehl buffers.
// Decides which requests are accepted and derives every flag from the
// next level, so the flags change on the same edge as level and have no
// combinational path from wr/rd.
//   clk, reset          : clock, synchronous active-high reset
//   wr, rd              : raw requests
//   wr_ok, rd_ok        : accepted requests (combinational)
//   level               : entry count 0..DEPTH
//   empty, full         : level == 0 / level == DEPTH
//   almost_empty/full   : level <= AEMPTY_LVL / level >= AFULL_LVL
module ehl_buffer_level_ctrl #(
  parameter int DEPTH      = 4,
  parameter int AFULL_LVL  = 3,
  parameter int AEMPTY_LVL = 1,
  parameter int LW         = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  output logic          wr_ok,
  output logic          rd_ok,
  output logic [LW-1:0] level,
  output logic          empty,
  output logic          full,
  output logic          almost_empty,
  output logic          almost_full
);

  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF  = LW'(AFULL_LVL);
  localparam logic [LW-1:0] LVL_AE  = LW'(AEMPTY_LVL);

  logic [LW-1:0] lvl_nxt;

  // A read frees a slot in the same cycle, so a full buffer still takes wr+rd.
  assign wr_ok = wr & (~full | rd);
  assign rd_ok = rd & ~empty;

  always_comb begin
    lvl_nxt = level;
    if (wr_ok && !rd_ok)
      lvl_nxt = level + 1'b1;
    else if (rd_ok && !wr_ok)
      lvl_nxt = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      level        <= lvl_nxt;
      empty        <= (lvl_nxt == '0);
      full         <= (lvl_nxt == LVL_MAX);
      almost_empty <= (lvl_nxt <= LVL_AE);
      almost_full  <= (lvl_nxt >= LVL_AF);
    end
  end

endmodule

// File: rtl/ehl_shift_buffer.sv
// Small FIFO built from a shift register; data_out always shows the oldest
// entry. MODE 0 writes at a level-derived pointer and shifts on read;
// MODE 1 shifts on write and reads at a level-derived pointer.
// Optional feature: define EHL_SHIFT_BUFFER_ERR_FLAGS_EN to get sticky
// overflow/underflow flags cleared by clr_err; otherwise they read 0.
//   clk, reset        : clock, synchronous active-high reset
//   wr, rd, data_in   : write request, read request, write data
//   clr_err           : clears the sticky error flags
//   data_out          : head (oldest) entry, 0 when empty
//   empty, full, almost_empty, almost_full, level : registered status
//   overflow, underflow : sticky rejected-write / rejected-read flags
module ehl_shift_buffer
  import ehl_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int MODE       = 0,
  parameter int AFULL_LVL  = (2 ** ADDR_WIDTH) - 1,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LW    = int'(level_width(DEPTH));

  logic wr_ok, rd_ok;
  logic wr_rej, rd_rej;

  assign wr_rej = wr & ~wr_ok;
  assign rd_rej = rd & ~rd_ok;

  ehl_buffer_level_ctrl #(
    .DEPTH      (DEPTH),
    .AFULL_LVL  (AFULL_LVL),
    .AEMPTY_LVL (AEMPTY_LVL),
    .LW         (LW)
  ) u_level_ctrl (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .rd           (rd),
    .wr_ok        (wr_ok),
    .rd_ok        (rd_ok),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full)
  );

  if (MODE == int'(EHL_BUF_WR_PTR)) begin : g_wr_ptr
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_idx;

    // A simultaneous read shifts everything down one slot, so the tail
    // slot for the new word is one lower.
    assign wr_idx   = ADDR_WIDTH'(level - LW'(rd_ok));
    assign data_out = mem[0];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
        if (rd_ok) begin
          for (int unsigned i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
          mem[DEPTH-1] <= '0;
        end
        if (wr_ok) mem[wr_idx] <= data_in;
      end
    end
  end else begin : g_rd_ptr
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_idx;

    // Oldest entry sits at level-1; wr+rd at full shifts the head out.
    assign rd_idx   = ADDR_WIDTH'(level - 1'b1);
    assign data_out = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_ok) begin
        for (int unsigned i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
        mem[0] <= data_in;
      end
    end
  end

`ifdef EHL_SHIFT_BUFFER_ERR_FLAGS_EN
  // A new rejection in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~clr_err) | wr_rej;
      underflow <= (underflow & ~clr_err) | rd_rej;
    end
  end
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

`ifndef SYNTHESIS
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH || AEMPTY_LVL < 0 ||
      AEMPTY_LVL > DEPTH - 1 || (MODE != 0 && MODE != 1)) begin : g_param_err
    $error("ehl_shift_buffer: parameter out of range (MODE=%0d AFULL_LVL=%0d AEMPTY_LVL=%0d DEPTH=%0d)",
           MODE, AFULL_LVL, AEMPTY_LVL, DEPTH);
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_rej) $warning("ehl_shift_buffer: error, write rejected while full");
    if (!reset && rd_rej) $warning("ehl_shift_buffer: error, read rejected while empty");
  end
`endif

endmodule

// File: tb/tb_ehl_shift_buffer.sv
// Directed bench for ehl_shift_buffer: both MODE values driven in lockstep
// with identical stimulus; error-flag expectations follow the build macro.
module tb_ehl_shift_buffer;

`ifdef EHL_SHIFT_BUFFER_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, wr, rd, clr_err;
  logic [7:0] data_in;

  logic [7:0] dout0, dout1;
  logic [2:0] lvl0, lvl1;
  logic e0, f0, ae0, af0, ov0, un0;
  logic e1, f1, ae1, af1, ov1, un1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ehl_shift_buffer #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .MODE(0), .AFULL_LVL(3), .AEMPTY_LVL(1)
  ) dut0 (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .data_in(data_in),
    .clr_err(clr_err), .data_out(dout0), .empty(e0), .full(f0),
    .almost_empty(ae0), .almost_full(af0), .level(lvl0),
    .overflow(ov0), .underflow(un0)
  );

  ehl_shift_buffer #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .MODE(1), .AFULL_LVL(3), .AEMPTY_LVL(1)
  ) dut1 (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .data_in(data_in),
    .clr_err(clr_err), .data_out(dout1), .empty(e1), .full(f1),
    .almost_empty(ae1), .almost_full(af1), .level(lvl1),
    .overflow(ov1), .underflow(un1)
  );

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic w, input logic rq,
                      input logic [7:0] d, input logic c);
    reset = r; wr = w; rd = rq; data_in = d; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  // Packed layout: {level[2:0], data_out[7:0], empty, full, ae, af, ov, un}
  task automatic expect_all(input string tag, input logic [2:0] lvl,
                            input logic [7:0] dout, input logic e,
                            input logic f, input logic ae, input logic af,
                            input logic ov, input logic un);
    logic [16:0] exp_v, obs0, obs1;
    exp_v = {lvl, dout, e, f, ae, af, ov & ERR_EN, un & ERR_EN};
    obs0  = {lvl0, dout0, e0, f0, ae0, af0, ov0, un0};
    obs1  = {lvl1, dout1, e1, f1, ae1, af1, ov1, un1};
    n_cmp++;
    assert (obs0 === exp_v) else begin
      n_err++;
      $error("FAIL %s mode0: observed %h required %h", tag, obs0, exp_v);
    end
    n_cmp++;
    assert (obs1 === exp_v) else begin
      n_err++;
      $error("FAIL %s mode1: observed %h required %h", tag, obs1, exp_v);
    end
  endtask

  initial begin
    //            r  w  rd  data   clr
    step(1, 0, 0, 8'h00, 0); expect_all("reset",      0, 8'h00, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 8'h11, 0); expect_all("fill1",      1, 8'h11, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 8'h22, 0); expect_all("fill2",      2, 8'h11, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 8'h33, 0); expect_all("fill3_af",   3, 8'h11, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 8'h44, 0); expect_all("fill4_full", 4, 8'h11, 0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 8'h55, 0); expect_all("overflow",   4, 8'h11, 0, 1, 0, 1, 1, 0);
    step(0, 0, 0, 8'h00, 1); expect_all("clr_ovf",    4, 8'h11, 0, 1, 0, 1, 0, 0);
    step(0, 1, 1, 8'h66, 0); expect_all("full_wr_rd", 4, 8'h22, 0, 1, 0, 1, 0, 0);
    step(0, 0, 1, 8'h00, 0); expect_all("drain1",     3, 8'h33, 0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 8'h00, 0); expect_all("drain2",     2, 8'h44, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 8'h00, 0); expect_all("drain3",     1, 8'h66, 0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 8'h00, 0); expect_all("drain4",     0, 8'h00, 1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 8'h00, 0); expect_all("underflow",  0, 8'h00, 1, 0, 1, 0, 0, 1);
    // clr_err coincides with a fresh rejected read: underflow stays set
    step(0, 1, 1, 8'h77, 1); expect_all("empty_wr_rd",1, 8'h77, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 8'h00, 1); expect_all("clr_unf",    1, 8'h77, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 8'h88, 0); expect_all("refill2",    2, 8'h77, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 8'h99, 0); expect_all("refill3",    3, 8'h77, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 8'hAA, 1); expect_all("mid_reset",  0, 8'h00, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 8'hBB, 0); expect_all("post_reset", 1, 8'hBB, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 8'h00, 0); expect_all("idle_hold",  1, 8'hBB, 0, 0, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
